// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe.
//   Instruction side : InValid, InReady, Instr
//   Result side      : OutValid, OutReady, Imm, Fmt, Illegal
//   Status           : IllegalCount
// master = producer/consumer around the generator, slave = the generator itself.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
);
    logic             InValid;
    logic             InReady;
    logic [31:0]      Instr;
    logic             OutValid;
    logic             OutReady;
    logic [XLEN-1:0]  Imm;
    logic [2:0]       Fmt;
    logic             Illegal;
    logic [CNT_W-1:0] IllegalCount;

    modport master (
        output InValid, Instr, OutReady,
        input  InReady, OutValid, Imm, Fmt, Illegal, IllegalCount
    );

    modport slave (
        input  InValid, Instr, OutReady,
        output InReady, OutValid, Imm, Fmt, Illegal, IllegalCount
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate generator. Decodes the instruction format from the
// opcode, builds the sign/zero-extended XLEN immediate and buffers the result
// in a FIFO_DEPTH-entry in-order queue whose head is presented from registers.
// Ports:
//   Clk   - clock, rising edge
//   RstN  - asynchronous active-low reset
//   bus   - imm_gen_pipe_if slave: InValid/InReady/Instr in, OutValid/OutReady/
//           Imm/Fmt/Illegal out, IllegalCount (saturating illegal-opcode count)
module imm_gen_pipe #(
    parameter int XLEN       = 64,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic         Clk,
    input  logic         RstN,
    imm_gen_pipe_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [2:0] FMT_I     = 3'd0;
    localparam logic [2:0] FMT_S     = 3'd1;
    localparam logic [2:0] FMT_B     = 3'd2;
    localparam logic [2:0] FMT_U     = 3'd3;
    localparam logic [2:0] FMT_J     = 3'd4;
    localparam logic [2:0] FMT_SHAMT = 3'd5;
    localparam logic [2:0] FMT_NONE  = 3'd7;

    // ---------------- decode ----------------
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic               is_shift;
    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [20:0] imm_j;
    logic [XLEN-1:0]    dec_imm;
    logic [2:0]         dec_fmt;
    logic               dec_ill;

    assign opcode   = bus.Instr[6:0];
    assign funct3   = bus.Instr[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign imm_i    = bus.Instr[31:20];
    assign imm_s    = {bus.Instr[31:25], bus.Instr[11:7]};
    assign imm_b    = {bus.Instr[31], bus.Instr[7], bus.Instr[30:25], bus.Instr[11:8], 1'b0};
    assign imm_u    = {bus.Instr[31:12], 12'b0};
    assign imm_j    = {bus.Instr[31], bus.Instr[19:12], bus.Instr[20], bus.Instr[30:21], 1'b0};

    // Size casts of the signed fields sign-extend to XLEN.
    always_comb begin
        dec_imm = '0;
        dec_fmt = FMT_NONE;
        dec_ill = 1'b0;
        case (opcode)
            7'b0000011, 7'b0001111, 7'b1100111: begin
                dec_fmt = FMT_I;
                dec_imm = XLEN'(imm_i);
            end
            7'b0010011, 7'b0011011: begin
                if (is_shift) begin
                    dec_fmt = FMT_SHAMT;
                    // Word shifts and RV32 only have a 5-bit shift amount.
                    if ((XLEN == 32) || (opcode == 7'b0011011))
                        dec_imm = XLEN'(bus.Instr[24:20]);
                    else
                        dec_imm = XLEN'(bus.Instr[25:20]);
                end else begin
                    dec_fmt = FMT_I;
                    dec_imm = XLEN'(imm_i);
                end
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                dec_imm = XLEN'(imm_s);
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                dec_imm = XLEN'(imm_b);
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FMT_U;
                dec_imm = XLEN'(imm_u);
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                dec_imm = XLEN'(imm_j);
            end
            7'b0110011, 7'b0111011, 7'b1110011: begin
                dec_fmt = FMT_NONE;
            end
            default: begin
                dec_ill = 1'b1;
            end
        endcase
    end

    // ---------------- FIFO ----------------
    logic [XLEN-1:0]  imm_mem [FIFO_DEPTH];
    logic [2:0]       fmt_mem [FIFO_DEPTH];
    logic             ill_mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             in_ready;
    logic             out_valid;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_ill;
    logic [CNT_W-1:0] ill_cnt;

    logic             push;
    logic             pop;
    logic [CW-1:0]    count_after_pop;
    logic [CW-1:0]    next_count;
    logic [PW-1:0]    next_rd;
    logic [XLEN-1:0]  head_imm;
    logic [2:0]       head_fmt;
    logic             head_ill;

    assign push = bus.InValid & in_ready;
    assign pop  = out_valid & bus.OutReady;

    // The head registers are loaded with whatever will be at the head after
    // this edge; when the queue would otherwise be empty the incoming entry
    // bypasses the storage so it appears one cycle after acceptance.
    always_comb begin
        count_after_pop = count - CW'(pop);
        next_count      = count_after_pop + CW'(push);
        next_rd         = rd_ptr + PW'(pop);
        if ((count_after_pop == '0) && push) begin
            head_imm = dec_imm;
            head_fmt = dec_fmt;
            head_ill = dec_ill;
        end else begin
            head_imm = imm_mem[next_rd];
            head_fmt = fmt_mem[next_rd];
            head_ill = ill_mem[next_rd];
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            imm_mem[wr_ptr] <= dec_imm;
            fmt_mem[wr_ptr] <= dec_fmt;
            ill_mem[wr_ptr] <= dec_ill;
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_imm   <= '0;
            out_fmt   <= '0;
            out_ill   <= 1'b0;
            ill_cnt   <= '0;
        end else begin
            count     <= next_count;
            rd_ptr    <= next_rd;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            in_ready  <= (next_count < DEPTH_C);
            out_valid <= (next_count != '0);
            // Head holds the last popped value once the queue drains.
            if (next_count != '0) begin
                out_imm <= head_imm;
                out_fmt <= head_fmt;
                out_ill <= head_ill;
            end
            if (push && dec_ill && !(&ill_cnt))
                ill_cnt <= ill_cnt + CNT_W'(1);
        end
    end

    assign bus.InReady      = in_ready;
    assign bus.OutValid     = out_valid;
    assign bus.Imm          = out_imm;
    assign bus.Fmt          = out_fmt;
    assign bus.Illegal      = out_ill;
    assign bus.IllegalCount = ill_cnt;
endmodule
